// File: rtl/uart_tx.sv
// uart_tx: serial transmitter paired with the team UART receiver.
// Sends start bit, N_DATA_BITS data bits (LSB first), an optional parity bit
// and N_STOP_BITS stop bits. Every bit lasts OVERSAMPLE ticks of i_en.
module uart_tx #(
    parameter int OVERSAMPLE  = 13,
    parameter int N_DATA_BITS = 8,
    parameter int N_STOP_BITS = 1,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_en,
    input  logic [N_DATA_BITS-1:0] i_data,
    input  logic                   i_data_valid,
    output logic                   o_ready,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = 4;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(N_DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(N_STOP_BITS - 1);
    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity of the latched word; odd parity is the inverted even parity.
    function automatic logic parity_of(input logic [N_DATA_BITS-1:0] word);
        return (^word) ^ (PARITY_ODD != 0);
    endfunction

    state_t                   state_r, state_s;
    logic [TICK_W-1:0]        tick_cnt_r, tick_cnt_s;
    logic [BIT_W-1:0]         bit_cnt_r, bit_cnt_s;
    logic [N_DATA_BITS-1:0]   shift_r, shift_s;
    logic                     parity_r, parity_s;
    logic                     tx_r, tx_s;
    logic                     done_r, done_s;

    // Next-state logic: acceptance in IDLE, otherwise advance one bit per OVERSAMPLE ticks.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        parity_s   = parity_r;
        tx_s       = tx_r;
        done_s     = 1'b0;

        if (state_r == ST_IDLE) begin
            tx_s = 1'b1;
            if (i_data_valid) begin
                // Start bit goes out on the acceptance edge regardless of i_en.
                state_s    = ST_START;
                tx_s       = 1'b0;
                shift_s    = i_data;
                parity_s   = parity_of(i_data);
                tick_cnt_s = TICK_ZERO;
                bit_cnt_s  = BIT_ZERO;
            end else begin
                tick_cnt_s = TICK_ZERO;
                bit_cnt_s  = BIT_ZERO;
            end
        end else if (i_en) begin
            if (tick_cnt_r == TICK_LAST) begin
                tick_cnt_s = TICK_ZERO;
                case (state_r)
                    ST_START: begin
                        state_s   = ST_DATA;
                        tx_s      = shift_r[0];
                        shift_s   = {1'b0, shift_r[N_DATA_BITS-1:1]};
                        bit_cnt_s = BIT_ZERO;
                    end
                    ST_DATA: begin
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_s = BIT_ZERO;
                            if (PARITY_EN != 0) begin
                                state_s = ST_PARITY;
                                tx_s    = parity_r;
                            end else begin
                                state_s = ST_STOP;
                                tx_s    = 1'b1;
                            end
                        end else begin
                            bit_cnt_s = bit_cnt_r + 1'b1;
                            tx_s      = shift_r[0];
                            shift_s   = {1'b0, shift_r[N_DATA_BITS-1:1]};
                        end
                    end
                    ST_PARITY: begin
                        state_s   = ST_STOP;
                        tx_s      = 1'b1;
                        bit_cnt_s = BIT_ZERO;
                    end
                    ST_STOP: begin
                        tx_s = 1'b1;
                        if (bit_cnt_r == STOP_LAST) begin
                            state_s   = ST_IDLE;
                            bit_cnt_s = BIT_ZERO;
                            done_s    = 1'b1;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 1'b1;
                        end
                    end
                    default: begin
                        state_s   = ST_IDLE;
                        tx_s      = 1'b1;
                        bit_cnt_s = BIT_ZERO;
                    end
                endcase
            end else begin
                tick_cnt_s = tick_cnt_r + 1'b1;
            end
        end else begin
            // No tick: counters and line hold.
            tick_cnt_s = tick_cnt_r;
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= TICK_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            shift_r    <= {N_DATA_BITS{1'b0}};
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            parity_r   <= parity_s;
            tx_r       <= tx_s;
            done_r     <= done_s;
        end
    end

    assign o_tx    = tx_r;
    assign o_done  = done_r;
    assign o_ready = (state_r == ST_IDLE);
    assign o_busy  = ~o_ready;

endmodule
